// File: rtl/flight_sequencer.sv
// flight_sequencer
// Game-level controller for the bird flight datapath: physics step enable,
// per-step jump request, Start/Stop/Ack sequencing, collision and score.
//
// Handshake (all toward the physics block, no ready/back-pressure path):
//   Start - 1-cycle pulse in the first RUN cycle (registered off the button rise).
//   Stop  - level, high while in HIT or OVER.
//   Ack   - 1-cycle pulse in the first IDLE cycle after OVER; Stop is already
//           low in that cycle. The three are never high together.
//
// Optional feature: define HISCORE_EN to add the HiScore[7:0] output and
// register (best score, cleared only by reset_n).
//
// State is visible one-hot on q_Idle/q_Run/q_Hit/q_Over. An illegal state
// code drives all four low and returns to IDLE.
module flight_sequencer #(
    parameter int unsigned TICK_DIV   = 833333,
    parameter int unsigned GROUND_Y   = 480,
    parameter int unsigned HOLD_TICKS = 30
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       BtnIn,
    input  logic [9:0] Bird_X_L,
    input  logic [9:0] Bird_X_R,
    input  logic [9:0] Bird_Y_T,
    input  logic [9:0] Bird_Y_B,
    input  logic [9:0] Pipe_X_L,
    input  logic [9:0] Pipe_X_R,
    input  logic [9:0] Gap_Y_T,
    input  logic [9:0] Gap_Y_B,
    output logic       Tick,
    output logic       BtnPress,
    output logic       Start,
    output logic       Stop,
    output logic       Ack,
    output logic [7:0] Score,
`ifdef HISCORE_EN
    output logic [7:0] HiScore,
`endif
    output logic       q_Idle,
    output logic       q_Run,
    output logic       q_Hit,
    output logic       q_Over
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
    localparam logic [9:0]    GROUND_ROW = 10'(GROUND_Y);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_RUN  = 4'b0010,
        S_HIT  = 4'b0100,
        S_OVER = 4'b1000
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          jump_q, jump_d;
    logic          btn_d_q;
    logic          start_q, start_d;
    logic          ack_q, ack_d;
    logic [7:0]    score_q, score_d;
    logic [9:0]    prev_pxr_q, prev_pxr_d;
`ifdef HISCORE_EN
    logic [7:0]    hiscore_q, hiscore_d;
`endif

    // Registered copies of the geometry inputs; collision and score only
    // ever look at these, never at the raw ports.
    logic [9:0] bird_xl_q, bird_xr_q, bird_yt_q, bird_yb_q;
    logic [9:0] pipe_xl_q, pipe_xr_q, gap_yt_q, gap_yb_q;

    logic btn_rise;
    logic tick_now;
    logic overlap;
    logic ground;
    logic collide;
    logic pipe_passed;

    assign btn_rise    = BtnIn & ~btn_d_q;
    assign tick_now    = (tick_cnt_q == TICK_LAST);
    assign overlap     = (bird_xr_q > pipe_xl_q) && (bird_xl_q < pipe_xr_q) &&
                         ((bird_yt_q < gap_yt_q) || (bird_yb_q > gap_yb_q));
    assign ground      = (bird_yb_q >= GROUND_ROW);
    assign collide     = overlap | ground;
    // A pipe counts once, on the step where its right edge moves past the bird.
    assign pipe_passed = (pipe_xr_q < bird_xl_q) && (prev_pxr_q >= bird_xl_q);

    // Capture button level and geometry every cycle.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_d_q   <= 1'b0;
            bird_xl_q <= '0;
            bird_xr_q <= '0;
            bird_yt_q <= '0;
            bird_yb_q <= '0;
            pipe_xl_q <= '0;
            pipe_xr_q <= '0;
            gap_yt_q  <= '0;
            gap_yb_q  <= '0;
        end else begin
            btn_d_q   <= BtnIn;
            bird_xl_q <= Bird_X_L;
            bird_xr_q <= Bird_X_R;
            bird_yt_q <= Bird_Y_T;
            bird_yb_q <= Bird_Y_B;
            pipe_xl_q <= Pipe_X_L;
            pipe_xr_q <= Pipe_X_R;
            gap_yt_q  <= Gap_Y_T;
            gap_yb_q  <= Gap_Y_B;
        end
    end

    // State register plus all sequencing state (counters, latch, score, pulses).
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            hold_cnt_q <= '0;
            jump_q     <= 1'b0;
            start_q    <= 1'b0;
            ack_q      <= 1'b0;
            score_q    <= '0;
            prev_pxr_q <= '0;
`ifdef HISCORE_EN
            hiscore_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            jump_q     <= jump_d;
            start_q    <= start_d;
            ack_q      <= ack_d;
            score_q    <= score_d;
            prev_pxr_q <= prev_pxr_d;
`ifdef HISCORE_EN
            hiscore_q  <= hiscore_d;
`endif
        end
    end

    // Next-state and combinational outputs for the game FSM.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        hold_cnt_d = hold_cnt_q;
        jump_d     = jump_q;
        start_d    = 1'b0;
        ack_d      = 1'b0;
        score_d    = score_q;
        prev_pxr_d = prev_pxr_q;
`ifdef HISCORE_EN
        hiscore_d  = hiscore_q;
`endif
        Tick       = 1'b0;
        BtnPress   = 1'b0;
        Stop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                hold_cnt_d = '0;
                jump_d     = 1'b0;
                if (btn_rise) begin
                    start_d    = 1'b1;
                    score_d    = '0;
                    // Seed the pass detector so a pipe already behind the
                    // bird at start is not counted.
                    prev_pxr_d = pipe_xr_q;
                    state_d    = S_RUN;
                end
            end

            S_RUN: begin
                Tick       = tick_now;
                tick_cnt_d = tick_now ? '0 : tick_cnt_q + TW'(1);
                if (tick_now) begin
                    // A rise on the tick cycle itself is delivered now.
                    BtnPress   = jump_q | btn_rise;
                    jump_d     = 1'b0;
                    prev_pxr_d = pipe_xr_q;
                    if (pipe_passed && (score_q != 8'hFF)) begin
                        score_d = score_q + 8'd1;
                    end
                    if (collide) begin
                        state_d    = S_HIT;
                        hold_cnt_d = '0;
                    end
                end else if (btn_rise) begin
                    jump_d = 1'b1;
                end
            end

            S_HIT: begin
                Stop       = 1'b1;
                Tick       = tick_now;
                tick_cnt_d = tick_now ? '0 : tick_cnt_q + TW'(1);
                jump_d     = 1'b0;
                if (tick_now) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = S_OVER;
`ifdef HISCORE_EN
                        if (score_q > hiscore_q) begin
                            hiscore_d = score_q;
                        end
`endif
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
            end

            S_OVER: begin
                Stop       = 1'b1;
                tick_cnt_d = '0;
                jump_d     = 1'b0;
                if (btn_rise) begin
                    ack_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d    = S_IDLE;
                tick_cnt_d = '0;
                hold_cnt_d = '0;
                jump_d     = 1'b0;
            end
        endcase
    end

    assign Start  = start_q;
    assign Ack    = ack_q;
    assign Score  = score_q;
`ifdef HISCORE_EN
    assign HiScore = hiscore_q;
`endif
    assign q_Idle = (state_q == S_IDLE);
    assign q_Run  = (state_q == S_RUN);
    assign q_Hit  = (state_q == S_HIT);
    assign q_Over = (state_q == S_OVER);

endmodule

// File: tb/tb_flight_sequencer.sv
// tb_flight_sequencer
// Directed tables and sequences for flight_sequencer plus a randomized run,
// all cross-checked cycle by cycle against a game-rule reference model.
// Optional feature checks are enabled when HISCORE_EN is defined.
`timescale 1ns/1ps
module tb_flight_sequencer;

    localparam int TD = 4;
    localparam int GY = 480;
    localparam int HT = 3;

    logic       Clk = 1'b0;
    logic       reset_n;
    logic       BtnIn;
    logic [9:0] Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B;
    logic [9:0] Pipe_X_L, Pipe_X_R, Gap_Y_T, Gap_Y_B;
    logic       Tick, BtnPress, Start, Stop, Ack;
    logic [7:0] Score;
`ifdef HISCORE_EN
    logic [7:0] HiScore;
`endif
    logic       q_Idle, q_Run, q_Hit, q_Over;

    int total = 0;
    int bad   = 0;

    flight_sequencer #(.TICK_DIV(TD), .GROUND_Y(GY), .HOLD_TICKS(HT)) dut (
        .Clk(Clk), .reset_n(reset_n), .BtnIn(BtnIn),
        .Bird_X_L(Bird_X_L), .Bird_X_R(Bird_X_R), .Bird_Y_T(Bird_Y_T), .Bird_Y_B(Bird_Y_B),
        .Pipe_X_L(Pipe_X_L), .Pipe_X_R(Pipe_X_R), .Gap_Y_T(Gap_Y_T), .Gap_Y_B(Gap_Y_B),
        .Tick(Tick), .BtnPress(BtnPress), .Start(Start), .Stop(Stop), .Ack(Ack),
        .Score(Score),
`ifdef HISCORE_EN
        .HiScore(HiScore),
`endif
        .q_Idle(q_Idle), .q_Run(q_Run), .q_Hit(q_Hit), .q_Over(q_Over)
    );

    // ---------------- clock ----------------
    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    typedef struct { int bxl, bxr, byt, byb, pxl, pxr, gyt, gyb; } geo_t;

    int   m_phase;      // 0 idle, 1 run, 2 hit, 3 over
    int   m_cyc;        // cycles since the game started
    int   m_hold;       // steps seen while hit
    int   m_score;
    int   m_prev_pxr;
    int   m_hi = 0;
    bit   m_jump, m_prev_btn, m_start, m_ack;
    geo_t m_reg;
    logic [16:0] exp_q[$];

    function automatic bit hits(geo_t g);
        bit ov;
        ov = (g.bxr > g.pxl) && (g.bxl < g.pxr) && ((g.byt < g.gyt) || (g.byb > g.gyb));
        return ov || (g.byb >= GY);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cyc = 0; m_hold = 0; m_score = 0; m_prev_pxr = 0; m_hi = 0;
        m_jump = 0; m_prev_btn = 0; m_start = 0; m_ack = 0;
        m_reg = '{0, 0, 0, 0, 0, 0, 0, 0};
    endtask

    // Scoreboard: predict this cycle's outputs, compare, then advance the model.
    always @(negedge Clk) begin : mon
        logic [16:0] act_v, exp_v;
        bit rise, tk;
        int exp_hi;
        geo_t cur;
        act_v = {Tick, BtnPress, Start, Stop, Ack, q_Idle, q_Run, q_Hit, q_Over, Score};
        exp_hi = m_hi;
        if (!reset_n) begin
            model_reset();
            exp_hi = 0;
            exp_q.push_back({5'b00000, 4'b1000, 8'd0});
        end else begin
            cur  = '{int'(Bird_X_L), int'(Bird_X_R), int'(Bird_Y_T), int'(Bird_Y_B),
                     int'(Pipe_X_L), int'(Pipe_X_R), int'(Gap_Y_T), int'(Gap_Y_B)};
            rise = BtnIn && !m_prev_btn;
            tk   = (m_phase == 1 || m_phase == 2) && ((m_cyc % TD) == TD - 1);
            exp_q.push_back({tk, (m_phase == 1) && tk && (m_jump || rise), m_start,
                             m_phase >= 2, m_ack, m_phase == 0, m_phase == 1,
                             m_phase == 2, m_phase == 3, 8'(m_score)});
            m_start = 0;
            m_ack   = 0;
            case (m_phase)
                0: if (rise) begin
                    m_start = 1; m_score = 0; m_prev_pxr = m_reg.pxr;
                    m_phase = 1; m_cyc = 0; m_jump = 0;
                end
                1: begin
                    if (tk) begin
                        if (m_reg.pxr < m_reg.bxl && m_prev_pxr >= m_reg.bxl)
                            m_score = (m_score < 255) ? m_score + 1 : 255;
                        m_prev_pxr = m_reg.pxr;
                        m_jump = 0;
                        if (hits(m_reg)) begin
                            m_phase = 2; m_hold = 0;
                        end
                    end else if (rise) begin
                        m_jump = 1;
                    end
                    m_cyc++;
                end
                2: begin
                    if (tk) begin
                        m_hold++;
                        if (m_hold == HT) begin
                            m_phase = 3;
                            if (m_score > m_hi) m_hi = m_score;
                        end
                    end
                    m_cyc++;
                end
                default: if (rise) begin
                    m_ack = 1; m_phase = 0;
                end
            endcase
            m_reg = cur;
            m_prev_btn = BtnIn;
        end
        exp_v = exp_q.pop_front();
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act_v, exp_v);
        end
`ifdef HISCORE_EN
        total++;
        if (int'(HiScore) != exp_hi) begin
            bad++;
            $display("FAIL cycle_hiscore t=%0t actual=%0d required=%0d", $time, HiScore, exp_hi);
        end
`endif
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic set_geo(int bxl, int bxr, int byt, int byb, int pxl, int pxr, int gyt, int gyb);
        Bird_X_L = 10'(bxl); Bird_X_R = 10'(bxr); Bird_Y_T = 10'(byt); Bird_Y_B = 10'(byb);
        Pipe_X_L = 10'(pxl); Pipe_X_R = 10'(pxr); Gap_Y_T = 10'(gyt); Gap_Y_B = 10'(gyb);
    endtask

    task automatic do_reset();
        next_cycle();
        reset_n = 1'b0;
        BtnIn   = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
    endtask

    task automatic start_game();
        BtnIn = 1'b1;
        next_cycle();
        BtnIn = 1'b0;
    endtask

    // Returns at the falling edge of the next Tick cycle; a missing Tick fails.
    task automatic wait_tick(string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 3 * TD && !seen; i++) begin
            @(negedge Clk);
            if (Tick) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s no Tick within %0d cycles", name, 3 * TD);
        end
    endtask

    // ---------------- collision vector table ----------------
    typedef struct {
        int bxl, bxr, byt, byb, pxl, pxr, gyt, gyb;
        int exp_hit;
    } geo_vec_t;
    geo_vec_t vecs[10];

    initial begin
        int ticks;
        vecs[0] = '{120, 140,  50,  70, 100, 140, 80, 200, 1};  // above gap inside pipe
        vecs[1] = '{ 10,  30, 460, 480, 300, 340, 80, 200, 1};  // ground row exactly
        vecs[2] = '{ 10,  30, 459, 479, 300, 340, 80, 200, 0};  // one row above ground
        vecs[3] = '{120, 140, 100, 120, 100, 140, 80, 200, 0};  // inside gap
        vecs[4] = '{120, 140, 190, 210, 100, 140, 80, 200, 1};  // below gap
        vecs[5] = '{ 80, 100,  50,  70, 100, 140, 80, 200, 0};  // right edge touches left edge
        vecs[6] = '{140, 160,  50,  70, 100, 140, 80, 200, 0};  // left edge touches right edge
        vecs[7] = '{139, 159,  50,  70, 100, 140, 80, 200, 1};  // one column overlap
        vecs[8] = '{120, 140,  80, 100, 100, 140, 80, 200, 0};  // top on gap top
        vecs[9] = '{120, 140, 180, 200, 100, 140, 80, 200, 0};  // bottom on gap bottom

        reset_n = 1'b0;
        BtnIn   = 1'b0;
        set_geo(20, 40, 100, 120, 600, 640, 80, 200);

        // --- reset values and start timing / tick cadence ---
        do_reset();
        @(negedge Clk);
        check("rst_idle", q_Idle, 1);
        check("rst_start", Start, 0);
        check("rst_stop", Stop, 0);
        check("rst_tick", Tick, 0);
        check("rst_score", Score, 0);
        repeat (5) next_cycle();
        BtnIn = 1'b1;
        @(negedge Clk);
        check("start_not_early", Start, 0);
        next_cycle();
        @(negedge Clk);
        check("start_run", q_Run, 1);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge Clk);
            check("start_pulse", Start, (k == 0) ? 1 : 0);
            check("tick_cadence", Tick, ((k % TD) == TD - 1) ? 1 : 0);
            check("held_btn_no_press", BtnPress, 0);
        end

        // --- jump latch: two rises between ticks collapse to one ---
        next_cycle();
        BtnIn = 1'b0;
        wait_tick("jl_sync");
        next_cycle(); BtnIn = 1'b1;
        next_cycle(); BtnIn = 1'b0;
        next_cycle(); BtnIn = 1'b1;
        @(negedge Clk);
        check("jl_no_press_off_tick", BtnPress, 0);
        next_cycle(); BtnIn = 1'b0;
        @(negedge Clk);
        check("jl_tick", Tick, 1);
        check("jl_press", BtnPress, 1);
        wait_tick("jl_next");
        check("jl_single_press", BtnPress, 0);
        next_cycle(); next_cycle(); next_cycle(); next_cycle();
        BtnIn = 1'b1;
        @(negedge Clk);
        check("jl_rise_on_tick", BtnPress, 1);
        next_cycle(); BtnIn = 1'b0;
        wait_tick("jl_after_rise_on_tick");
        check("jl_rise_on_tick_not_kept", BtnPress, 0);

        // --- collision geometry table ---
        foreach (vecs[i]) begin
            do_reset();
            set_geo(vecs[i].bxl, vecs[i].bxr, vecs[i].byt, vecs[i].byb,
                    vecs[i].pxl, vecs[i].pxr, vecs[i].gyt, vecs[i].gyb);
            next_cycle();
            start_game();
            wait_tick("geo_tick");
            @(negedge Clk);
            check($sformatf("geo%0d_hit", i), q_Hit, vecs[i].exp_hit);
            check($sformatf("geo%0d_stop", i), Stop, vecs[i].exp_hit);
            check($sformatf("geo%0d_run", i), q_Run, 1 - vecs[i].exp_hit);
        end

        // --- HIT hold with button ignored, then OVER and Ack ---
        do_reset();
        set_geo(20, 40, 100, 120, 600, 640, 80, 200);
        start_game();
        wait_tick("hit_sync");
        next_cycle();
        set_geo(120, 140, 50, 70, 100, 140, 80, 200);
        wait_tick("hit_collide");
        ticks = 0;
        for (int i = 0; i < HT * TD; i++) begin
            next_cycle();
            BtnIn = (i % 2 == 0);
            @(negedge Clk);
            if (i == 0) check("hit_stop", Stop, 1);
            check("hit_state", q_Hit, 1);
            if (Tick) begin
                ticks++;
                check("hit_press_blocked", BtnPress, 0);
            end
        end
        check("hit_tick_count", ticks, HT);
        next_cycle();
        @(negedge Clk);
        check("over_state", q_Over, 1);
        check("over_stop", Stop, 1);
        for (int i = 0; i < 2 * TD; i++) begin
            @(negedge Clk);
            check("over_no_tick", Tick, 0);
        end
        next_cycle(); BtnIn = 1'b1;
        @(negedge Clk);
        check("ack_not_early", Ack, 0);
        next_cycle(); BtnIn = 1'b0;
        @(negedge Clk);
        check("ack_pulse", Ack, 1);
        check("ack_stop_low", Stop, 0);
        check("ack_idle", q_Idle, 1);
        next_cycle();
        @(negedge Clk);
        check("ack_one_cycle", Ack, 0);

        // --- score increment and saturation ---
        do_reset();
        set_geo(20, 40, 100, 120, 5, 25, 80, 200);
        next_cycle();
        start_game();
        wait_tick("sc_first");
        next_cycle();
        Pipe_X_L = 10'd0; Pipe_X_R = 10'd15;
        wait_tick("sc_pass");
        next_cycle();
        check("score_one", Score, 1);
        for (int n = 0; n < 255; n++) begin
            Pipe_X_L = 10'd5; Pipe_X_R = 10'd25;
            wait_tick("sc_back");
            next_cycle();
            Pipe_X_L = 10'd0; Pipe_X_R = 10'd15;
            wait_tick("sc_pass");
            next_cycle();
            if (n == 253) check("score_255", Score, 255);
        end
        check("score_saturate", Score, 255);

        // --- score into OVER, Ack keeps score, restart clears it, reset mid-run ---
        do_reset();
        set_geo(20, 40, 100, 120, 5, 25, 80, 200);
        next_cycle();
        start_game();
        for (int n = 0; n < 7; n++) begin
            Pipe_X_L = 10'd0; Pipe_X_R = 10'd15;
            wait_tick("s7_pass");
            next_cycle();
            Pipe_X_L = 10'd5; Pipe_X_R = 10'd25;
            wait_tick("s7_back");
            next_cycle();
        end
        Bird_Y_T = 10'd460; Bird_Y_B = 10'd480;
        wait_tick("s7_ground");
        for (int n = 0; n < HT; n++) wait_tick("s7_hold");
        next_cycle();
        @(negedge Clk);
        check("s7_over", q_Over, 1);
        check("s7_score", Score, 7);
`ifdef HISCORE_EN
        check("s7_hiscore", HiScore, 7);
`endif
        next_cycle(); BtnIn = 1'b1;
        next_cycle(); BtnIn = 1'b0;
        @(negedge Clk);
        check("s7_ack", Ack, 1);
        check("s7_score_held", Score, 7);
        set_geo(20, 40, 100, 120, 600, 640, 80, 200);
        next_cycle();
        start_game();
        @(negedge Clk);
        check("restart_score", Score, 0);
        check("restart_run", q_Run, 1);
`ifdef HISCORE_EN
        check("restart_hiscore", HiScore, 7);
`endif
        next_cycle();
        next_cycle();
        reset_n = 1'b0;
        #1;
        check("midrst_idle", q_Idle, 1);
        check("midrst_run", q_Run, 0);
        check("midrst_start", Start, 0);
        check("midrst_stop", Stop, 0);
        check("midrst_tick", Tick, 0);
        check("midrst_score", Score, 0);
`ifdef HISCORE_EN
        check("midrst_hiscore", HiScore, 0);
`endif
        next_cycle();
        reset_n = 1'b1;
        next_cycle();

        // --- randomized play checked by the reference model ---
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            BtnIn = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) begin
                int pxr, byt;
                pxr = $urandom_range(60, 180);
                if ($urandom_range(0, 31) == 0)      byt = 470;
                else if ($urandom_range(0, 39) == 0) byt = 30;
                else                                 byt = $urandom_range(70, 280);
                set_geo(100, 120, byt, byt + 20, pxr - 40, pxr, 60, 320);
            end
        end
        next_cycle();
        BtnIn = 1'b0;
        repeat (2) next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net in case a sequence stalls.
    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
